spi_ram_slave_gen: RTL and testbench

- Parametrised successor to the fixed 8-bit SPI-slave-plus-RAM pair.
- SPI slave clocked directly by the SPI clock, with a single-port synchronous RAM behind it, in one block.
- Address and data widths and RAM depth are generic. Adds burst (auto-increment) writes and reads within one ss_n frame, plus an abort status pulse.
- Sits at the chip pin boundary; the frame protocol is fully defined below.

---
 rtl/spi_ram_slave_gen_pkg.sv | 31 +++
 rtl/spi_ram_slave_gen_sp_ram.sv | 26 ++
 rtl/spi_ram_slave_gen.sv | 187 ++++++++++++++++++
 tb/tb_spi_ram_slave_gen.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/spi_ram_slave_gen_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// spi_ram_slave_gen_pkg : command codes, FSM states, counter-width helper.
// Revision: 1.0
// ---------------------------------------------------------------------------
package spi_ram_slave_gen_pkg;

  localparam logic [1:0] CMD_WR_ADDR = 2'b00;
  localparam logic [1:0] CMD_WR_DATA = 2'b01;
  localparam logic [1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [1:0] CMD_RD_DATA = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CMD     = 3'd1,
    S_WR_ADDR = 3'd2,
    S_WR_DATA = 3'd3,
    S_RD_ADDR = 3'd4,
    S_RD_TURN = 3'd5,
    S_RD_LOAD = 3'd6,
    S_RD_DATA = 3'd7
  } state_t;

  function automatic int cnt_width(input int addr_w, input int data_w);
    int m;
    m = (addr_w > data_w) ? addr_w : data_w;
    return $clog2(m + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/spi_ram_slave_gen_sp_ram.sv
`default_nettype none
// ---------------------------------------------------------------------------
// spi_sp_ram : single-port synchronous RAM, registered read (read-before-write).
// Revision: 1.0
// ---------------------------------------------------------------------------
module spi_sp_ram #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= din;
    dout <= mem[addr];
  end

endmodule
`default_nettype wire

// File: rtl/spi_ram_slave_gen.sv
`default_nettype none
// ---------------------------------------------------------------------------
// spi_ram_slave_gen : SPI-clocked slave with burst read/write into a local RAM.
// Revision: 1.0
// ---------------------------------------------------------------------------
module spi_ram_slave_gen
  import spi_ram_slave_gen_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 8,
  parameter int DEPTH    = 256,
  parameter int AUTO_INC = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic ss_n,
  input  logic mosi,
  output logic miso,
  output logic frame_abort,
  output logic busy
);

  localparam int CNT_W = cnt_width(ADDR_W, DATA_W);
  localparam int SH_W  = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
  localparam logic [ADDR_W:0] DEPTH_EXT = (ADDR_W + 1)'(DEPTH);

  state_t            state, state_nxt;
  logic              cmd_hi;
  logic              done;
  logic [CNT_W-1:0]  cnt;
  logic [SH_W-2:0]   rx_shift;
  logic [DATA_W-1:0] tx_shift;
  logic [ADDR_W-1:0] wr_addr, rd_addr;

  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_din, ram_dout;

  logic [ADDR_W-1:0] addr_in, addr_mod;
  logic [DATA_W-1:0] data_in;
  logic              last_addr_bit, last_data_bit;

  function automatic logic [ADDR_W-1:0] inc_wrap(input logic [ADDR_W-1:0] a);
    return (a == ADDR_W'(DEPTH - 1)) ? '0 : a + 1'b1;
  endfunction

  assign addr_in       = {rx_shift[ADDR_W-2:0], mosi};
  assign data_in       = {rx_shift[DATA_W-2:0], mosi};
  assign addr_mod      = ADDR_W'({1'b0, addr_in} % DEPTH_EXT);
  assign last_addr_bit = (cnt == CNT_W'(ADDR_W - 1));
  assign last_data_bit = (cnt == CNT_W'(DATA_W - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    ram_we    = 1'b0;
    ram_din   = data_in;
    ram_addr  = wr_addr;
    busy      = (state != S_IDLE);
    if (state == S_RD_TURN || state == S_RD_LOAD || state == S_RD_DATA)
      ram_addr = rd_addr;
    if (ss_n) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE: state_nxt = S_CMD;
        S_CMD: begin
          case ({cmd_hi, mosi})
            CMD_WR_ADDR: state_nxt = S_WR_ADDR;
            CMD_WR_DATA: state_nxt = S_WR_DATA;
            CMD_RD_ADDR: state_nxt = S_RD_ADDR;
            CMD_RD_DATA: state_nxt = S_RD_TURN;
            default:     state_nxt = S_IDLE;
          endcase
        end
        S_WR_DATA: ram_we = !done && last_data_bit;
        S_RD_TURN: state_nxt = S_RD_LOAD;
        S_RD_LOAD: state_nxt = S_RD_DATA;
        default:   state_nxt = state;
      endcase
    end
  end

  // Bits are only meaningful while ss_n is low; a high ss_n ends the frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmd_hi      <= 1'b0;
      done        <= 1'b0;
      cnt         <= '0;
      rx_shift    <= '0;
      tx_shift    <= '0;
      wr_addr     <= '0;
      rd_addr     <= '0;
      miso        <= 1'b0;
      frame_abort <= 1'b0;
    end else begin
      frame_abort <= 1'b0;
      if (ss_n) begin
        if (state != S_IDLE) begin
          frame_abort <= (cnt != '0);
          cnt         <= '0;
          done        <= 1'b0;
          rx_shift    <= '0;
          miso        <= 1'b0;
        end
      end else begin
        case (state)
          S_IDLE: begin
            cmd_hi <= mosi;
            cnt    <= CNT_W'(1);
            done   <= 1'b0;
          end
          S_CMD: cnt <= '0;
          S_WR_ADDR, S_RD_ADDR: begin
            if (!done) begin
              rx_shift <= (SH_W - 1)'({rx_shift, mosi});
              if (last_addr_bit) begin
                cnt  <= '0;
                done <= 1'b1;
                if (state == S_WR_ADDR) wr_addr <= addr_mod;
                else                    rd_addr <= addr_mod;
              end else begin
                cnt <= cnt + 1'b1;
              end
            end
          end
          S_WR_DATA: begin
            if (!done) begin
              rx_shift <= (SH_W - 1)'({rx_shift, mosi});
              if (last_data_bit) begin
                cnt <= '0;
                if (AUTO_INC != 0) wr_addr <= inc_wrap(wr_addr);
                else               done    <= 1'b1;
              end else begin
                cnt <= cnt + 1'b1;
              end
            end
          end
          S_RD_LOAD: begin
            miso     <= ram_dout[DATA_W-1];
            tx_shift <= {ram_dout[DATA_W-2:0], 1'b0};
            if (AUTO_INC != 0) rd_addr <= inc_wrap(rd_addr);
          end
          S_RD_DATA: begin
            if (!done) begin
              if (last_data_bit) begin
                cnt <= '0;
                // RAM output already holds the next word, so the stream has no gap.
                if (AUTO_INC != 0) begin
                  miso     <= ram_dout[DATA_W-1];
                  tx_shift <= {ram_dout[DATA_W-2:0], 1'b0};
                  rd_addr  <= inc_wrap(rd_addr);
                end else begin
                  miso <= 1'b0;
                  done <= 1'b1;
                end
              end else begin
                cnt      <= cnt + 1'b1;
                miso     <= tx_shift[DATA_W-1];
                tx_shift <= {tx_shift[DATA_W-2:0], 1'b0};
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  spi_sp_ram #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk (clk),
    .we  (ram_we),
    .addr(ram_addr),
    .din (ram_din),
    .dout(ram_dout)
  );

endmodule
`default_nettype wire

// File: tb/tb_spi_ram_slave_gen.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_spi_ram_slave_gen : scoreboard bench for default and generic-width slaves.
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_spi_ram_slave_gen;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ss_n = 1'b1, mosi = 1'b0;
  logic ss_n2 = 1'b1, mosi2 = 1'b0;
  logic miso, frame_abort, busy;
  logic miso2, frame_abort2, busy2;

  int total = 0;
  int bad = 0;
  int aborts = 0;
  int aborts2 = 0;
  logic win = 1'b0;
  int   cur = 0;
  logic [15:0] exp_q [$];

  always #5 clk = ~clk;

  spi_ram_slave_gen #(.DATA_W(8), .ADDR_W(8), .DEPTH(256), .AUTO_INC(1)) dut (
    .clk(clk), .rst(rst), .ss_n(ss_n), .mosi(mosi),
    .miso(miso), .frame_abort(frame_abort), .busy(busy)
  );

  spi_ram_slave_gen #(.DATA_W(16), .ADDR_W(4), .DEPTH(10), .AUTO_INC(1)) dut_g (
    .clk(clk), .rst(rst), .ss_n(ss_n2), .mosi(mosi2),
    .miso(miso2), .frame_abort(frame_abort2), .busy(busy2)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Monitor: samples miso mid-low-phase while a read window is open.
  initial begin
    logic [15:0] acc;
    int nb;
    acc = '0;
    nb  = 0;
    forever begin
      @(negedge clk);
      #2;
      if (frame_abort === 1'b1)  aborts++;
      if (frame_abort2 === 1'b1) aborts2++;
      if (win) begin
        acc = {acc[14:0], (cur != 0) ? miso2 : miso};
        nb++;
        if (nb == ((cur != 0) ? 16 : 8)) begin
          if (exp_q.size() == 0) chk("rd_word_unexpected", 32'(acc), 32'hDEAD_BEEF);
          else                   chk("rd_word", 32'(acc), 32'(exp_q.pop_front()));
          acc = '0;
          nb  = 0;
        end
      end
    end
  end

  task automatic send_bits(input int sel, input logic [63:0] val, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      @(negedge clk);
      if (sel != 0) begin ss_n2 = 1'b0; mosi2 = val[i]; end
      else          begin ss_n  = 1'b0; mosi  = val[i]; end
    end
  endtask

  task automatic end_frame(input int sel);
    @(negedge clk);
    win = 1'b0;
    if (sel != 0) begin ss_n2 = 1'b1; mosi2 = 1'b0; end
    else          begin ss_n  = 1'b1; mosi  = 1'b0; end
    @(negedge clk);
  endtask

  task automatic read_words(input int sel, input int nwords);
    int w;
    w = (sel != 0) ? 16 : 8;
    send_bits(sel, 64'b11, 2);
    send_bits(sel, 64'b00, 2);
    cur = sel;
    for (int i = 0; i < nwords * w; i++) begin
      @(negedge clk);
      win = 1'b1;
      if (sel != 0) mosi2 = 1'b0;
      else          mosi  = 1'b0;
    end
    end_frame(sel);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    @(negedge clk);
    #1;
    chk("rst_miso", 32'(miso), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_abort", 32'(frame_abort), 0);
    chk("rst_busy_g", 32'(busy2), 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // 1: single write then read
    send_bits(0, {2'b00, 8'h12}, 10);
    #6;
    chk("busy_in_frame", 32'(busy), 1);
    end_frame(0);
    send_bits(0, {2'b01, 8'hA5}, 10); end_frame(0);
    send_bits(0, {2'b10, 8'h12}, 10); end_frame(0);
    exp_q.push_back(16'h00A5);
    read_words(0, 1);

    // 2: burst write wrapping past 0xFF, then one more word from wr_addr=0x01
    send_bits(0, {2'b00, 8'hFE}, 10); end_frame(0);
    send_bits(0, {2'b01, 8'h11, 8'h22, 8'h33}, 26); end_frame(0);
    send_bits(0, {2'b01, 8'h44}, 10); end_frame(0);

    // 3: gapless burst reads across the wrap
    send_bits(0, {2'b10, 8'hFE}, 10); end_frame(0);
    exp_q.push_back(16'h0011); exp_q.push_back(16'h0022); exp_q.push_back(16'h0033);
    read_words(0, 3);
    send_bits(0, {2'b10, 8'h00}, 10); end_frame(0);
    exp_q.push_back(16'h0033); exp_q.push_back(16'h0044);
    read_words(0, 2);

    // 4: partial word aborted
    send_bits(0, {2'b00, 8'h40}, 10); end_frame(0);
    send_bits(0, {2'b01, 8'h5A}, 10); end_frame(0);
    send_bits(0, {2'b00, 8'h40}, 10); end_frame(0);
    send_bits(0, {2'b01, 5'b10110}, 7);
    @(negedge clk);
    ss_n = 1'b1;
    @(negedge clk);
    #1;
    chk("abort_pulse", 32'(frame_abort), 1);
    chk("abort_busy", 32'(busy), 0);
    @(negedge clk);
    #1;
    chk("abort_one_cycle", 32'(frame_abort), 0);
    send_bits(0, {2'b10, 8'h40}, 10); end_frame(0);
    exp_q.push_back(16'h005A);
    read_words(0, 1);

    // 5: generic widths, wrap at DEPTH=10, out-of-range address folded
    send_bits(1, {2'b00, 4'h9}, 6); end_frame(1);
    send_bits(1, {2'b01, 16'hBEEF, 16'h1234}, 34); end_frame(1);
    send_bits(1, {2'b10, 4'h9}, 6); end_frame(1);
    exp_q.push_back(16'hBEEF); exp_q.push_back(16'h1234);
    read_words(1, 2);
    send_bits(1, {2'b00, 4'hC}, 6); end_frame(1);
    send_bits(1, {2'b01, 16'hCAFE}, 18); end_frame(1);
    send_bits(1, {2'b10, 4'hC}, 6); end_frame(1);
    exp_q.push_back(16'hCAFE);
    read_words(1, 1);

    // 6: asynchronous reset in the middle of a read word
    send_bits(0, {2'b10, 8'h12}, 10); end_frame(0);
    send_bits(0, 64'b11, 2);
    send_bits(0, 64'b00, 2);
    send_bits(0, 64'b000, 3);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_mid_miso", 32'(miso), 0);
    chk("rst_mid_busy", 32'(busy), 0);
    chk("rst_mid_abort", 32'(frame_abort), 0);
    ss_n = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    exp_q.push_back(16'h0033);
    read_words(0, 1);
    send_bits(0, {2'b10, 8'h12}, 10); end_frame(0);
    exp_q.push_back(16'h00A5);
    read_words(0, 1);

    repeat (3) @(negedge clk);
    chk("queue_drained", 32'(exp_q.size()), 0);
    chk("abort_count", 32'(aborts), 1);
    chk("abort_count_g", 32'(aborts2), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
